// File: rtl/wide_mult_sequencer.sv
// Sequences one 256x256 request as two 256x128 passes through the external
// multiplier pipeline and recombines the partial products into a 512-bit result.
module wide_mult_sequencer #(
  parameter int MUL_LATENCY = 7,
  parameter int X_W         = 256,
  parameter int YS_W        = 128
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [X_W-1:0]          req_x,
  input  logic [2*YS_W-1:0]       req_y,
  output logic                    mul_in_valid,
  output logic [X_W-1:0]          mul_x,
  output logic [YS_W-1:0]         mul_y,
  input  logic [X_W+YS_W-1:0]     mul_p,
  input  logic                    mul_out_valid,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [X_W+2*YS_W-1:0]   res_p,
  output logic                    err_timeout,
  output logic                    err_spurious
);

  localparam int CW = $clog2(MUL_LATENCY + 2) + 1;
  localparam logic [CW-1:0] FLUSH_LAST = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0] WAIT_MAX   = CW'(MUL_LATENCY + 1);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_ISSUE_LO,
    S_ISSUE_HI,
    S_WAIT_LO,
    S_WAIT_HI,
    S_DONE
  } state_t;

  state_t                   state_reg, state_next;
  // One counter serves as the flush counter in FLUSH and the wait counter in WAIT_*.
  logic [CW-1:0]            cnt_reg, cnt_next;
  logic [CW-1:0]            cnt_inc;
  logic [2*YS_W-1:0]        y_reg;
  logic [X_W-1:0]           mul_x_reg;
  logic [X_W+2*YS_W-1:0]    acc_reg;
  logic [X_W+2*YS_W-1:0]    res_p_reg;
  logic                     err_timeout_reg;
  logic                     err_spurious_reg;

  logic accept;
  logic in_wait;
  logic wait_expired;
  logic lo_capture;
  logic hi_capture;
  logic timeout_hit;
  logic spurious_hit;

  assign cnt_inc      = cnt_reg + 1'b1;
  assign accept       = (state_reg == S_IDLE) && req_valid;
  assign in_wait      = (state_reg == S_WAIT_LO) || (state_reg == S_WAIT_HI);
  assign wait_expired = (cnt_inc == WAIT_MAX);
  assign lo_capture   = (state_reg == S_WAIT_LO) && mul_out_valid;
  assign hi_capture   = (state_reg == S_WAIT_HI) && mul_out_valid;
  assign timeout_hit  = in_wait && !mul_out_valid && wait_expired;
  assign spurious_hit = mul_out_valid &&
                        ((state_reg == S_IDLE) || (state_reg == S_ISSUE_LO) ||
                         (state_reg == S_ISSUE_HI) || (state_reg == S_DONE));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_FLUSH;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      S_FLUSH: begin
        cnt_next = cnt_inc;
        if (cnt_reg == FLUSH_LAST) state_next = S_IDLE;
      end
      S_IDLE: begin
        if (req_valid) state_next = S_ISSUE_LO;
      end
      S_ISSUE_LO: state_next = S_ISSUE_HI;
      S_ISSUE_HI: begin
        state_next = S_WAIT_LO;
        cnt_next   = '0;
      end
      S_WAIT_LO: begin
        cnt_next = cnt_inc;
        if (mul_out_valid)     state_next = S_WAIT_HI;
        else if (wait_expired) state_next = S_IDLE;
      end
      S_WAIT_HI: begin
        cnt_next = cnt_inc;
        if (mul_out_valid)     state_next = S_DONE;
        else if (wait_expired) state_next = S_IDLE;
      end
      S_DONE: begin
        if (res_ready) state_next = S_IDLE;
      end
      default: state_next = S_FLUSH;
    endcase
  end

  always_comb begin
    req_ready    = 1'b0;
    mul_in_valid = 1'b0;
    mul_y        = '0;
    res_valid    = 1'b0;
    case (state_reg)
      S_IDLE:     req_ready = 1'b1;
      S_ISSUE_LO: begin
        mul_in_valid = 1'b1;
        mul_y        = y_reg[YS_W-1:0];
      end
      S_ISSUE_HI: begin
        mul_in_valid = 1'b1;
        mul_y        = y_reg[2*YS_W-1:YS_W];
      end
      S_DONE:     res_valid = 1'b1;
      default:    ;
    endcase
  end

  // The high partial product is weighted by 2^YS_W; the sum fits in 512 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      y_reg            <= '0;
      mul_x_reg        <= '0;
      acc_reg          <= '0;
      res_p_reg        <= '0;
      err_timeout_reg  <= 1'b0;
      err_spurious_reg <= 1'b0;
    end else begin
      if (accept) begin
        mul_x_reg <= req_x;
        y_reg     <= req_y;
      end
      if (lo_capture)   acc_reg          <= {{YS_W{1'b0}}, mul_p};
      if (hi_capture)   res_p_reg        <= acc_reg + {mul_p, {YS_W{1'b0}}};
      if (timeout_hit)  err_timeout_reg  <= 1'b1;
      if (spurious_hit) err_spurious_reg <= 1'b1;
    end
  end

  assign mul_x        = mul_x_reg;
  assign res_p        = res_p_reg;
  assign err_timeout  = err_timeout_reg;
  assign err_spurious = err_spurious_reg;

endmodule

// File: doc/wide_mult_sequencer.md
Name: wide_mult_sequencer

Overview:
- Drives the 256x128 constant-Karatsuba multiplier pipeline twice per request to form a full 256x256 -> 512-bit product.
- Sits directly upstream and downstream of that multiplier. It issues the low and high 128-bit slices of Y on consecutive cycles, then captures both 384-bit partial products.
- Combines them as P_lo + (P_hi << 128) and presents the result through a valid/ready port to the modular reduction stage.

Parameters:
- MUL_LATENCY, 7, cycles from a mul_in_valid cycle to the matching mul_out_valid cycle.
- X_W, 256, width of the X operand.
- YS_W, 128, multiplier Y slice width; the request Y width is 2*YS_W.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request valid
- req_ready  out  1  block can accept a request
- req_x  in  256  X operand
- req_y  in  256  Y operand
- mul_in_valid  out  1  to multiplier in_valid
- mul_x  out  256  to multiplier X
- mul_y  out  128  to multiplier Y
- mul_p  in  384  from multiplier P
- mul_out_valid  in  1  from multiplier out_valid
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts the result
- res_p  out  512  full product
- err_timeout  out  1  sticky: an expected result never arrived
- err_spurious  out  1  sticky: unexpected mul_out_valid

Behaviour:
- Reset values: req_ready=0, mul_in_valid=0, mul_x=0, mul_y=0, res_valid=0, res_p=0, err_*=0, state=FLUSH.
- FLUSH
  - Entered on reset. Lasts MUL_LATENCY cycles after reset deasserts, counted by a flush counter.
  - mul_out_valid is ignored and raises no error; this covers stale multiplier stages that are not reset.
  - Then go to IDLE.
- IDLE
  - req_ready=1.
  - On req_valid&&req_ready: latch req_x into mul_x and req_y into y_reg, then go to ISSUE_LO.
- ISSUE_LO (one cycle): mul_in_valid=1, mul_y=y_reg[127:0]. Then ISSUE_HI.
- ISSUE_HI (one cycle): mul_in_valid=1, mul_y=y_reg[255:128]. Then WAIT_LO; the wait counter starts at 0.
- WAIT_LO: on mul_out_valid, acc <= {128'b0, mul_p}, then go to WAIT_HI.
- WAIT_HI: on mul_out_valid, res_p <= acc + {mul_p, 128'b0} (512-bit add, no carry out possible), res_valid <= 1, then go to DONE.
- Timeout in WAIT_LO/WAIT_HI:
  - The wait counter increments every cycle.
  - If it reaches MUL_LATENCY+1 with no arrival, set err_timeout, drop the transaction and go to IDLE.
- DONE
  - res_valid held high and res_p stable until res_ready.
  - On the handshake, res_valid <= 0 and go to IDLE; res_p keeps its value.
- Outside the flush window, mul_out_valid in IDLE, ISSUE_LO, ISSUE_HI or DONE sets err_spurious and is otherwise ignored.
- mul_x is held constant from acceptance until the next acceptance. It is not changed mid-transaction.
- mul_in_valid is never asserted outside ISSUE_LO/ISSUE_HI. Exactly one transaction is outstanding at a time.
- Latency (MUL_LATENCY=7), taking the handshake cycle as cycle 0:
  - mul_in_valid in cycles 1 and 2.
  - Low result in cycle 8, high result in cycle 9.
  - res_valid first high in cycle 10.
  - IDLE again in cycle 11 if res_ready=1 in cycle 10.
- Reset mid-operation: aborts immediately. All outputs return to reset values, acc is discarded, and the block re-enters FLUSH. The error flags are cleared only by reset.
- req_ready is combinational from state only (IDLE). It does not depend on req_valid.

Test Plan:
1. Basic product: reset 2 cycles, wait out FLUSH. Then X=1, Y=2^128+3 -> mul_y=0x3 in cycle 1 and 0x1 in cycle 2; res_p=2^128+3 in cycle 10; no error flags.
2. Max operands: X=2^256-1, Y=2^256-1, using a behavioural multiplier model -> res_p=(2^256-1)^2; low 128 bits of the cross term carry correctly.
3. Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_valid and res_p are stable and req_ready=0. Release -> IDLE the next cycle; a back-to-back request is accepted immediately.
4. Timeout: the model drops the high result -> err_timeout=1 at wait count 8, block returns to IDLE; a following request completes correctly and err_timeout stays 1.
5. Spurious and flush:
   - Pulse mul_out_valid in IDLE -> err_spurious=1.
   - After reset, pulse mul_out_valid within the first 7 cycles -> no error.
6. Reset mid-op: assert reset in WAIT_HI -> cycle after: res_valid=0, req_ready=0, state FLUSH. The late multiplier result arriving during FLUSH is ignored; a new request yields the correct product.
